// File: rtl/hub75_bcm_ctrl.sv
// -----------------------------------------------------------------------------
// hub75_bcm_ctrl
//
// Purpose
//   Scans one HUB75 64x64 panel (1:32 scan) using binary-code modulation.
//   For every (row, plane) pair the controller:
//     1. shifts COLS pixels out of the frame RAM,
//     2. blanks the panel for BLANK_CYC cycles,
//     3. latches the shifted data and drives the row address,
//     4. shows the plane for BASE_ON << plane cycles.
//   All planes of a row are shown before moving to the next row. At the end of
//   a frame the front/back buffers swap if the writer has asked for it.
//
// Ports
//   i_clk          system clock
//   i_rst          synchronous reset, active high
//   i_enable       run scanning (examined in IDLE and when leaving SHOW)
//   i_swap_req     level: writer has a new frame in the back buffer
//   i_brightness   global brightness 0..15 (only with BCM_BRIGHTNESS_EN)
//   o_swap_ack     1-cycle pulse when the buffers swap
//   o_buf_sel      front buffer being read
//   o_rd_en        frame-RAM read strobe (data valid next cycle)
//   o_col          RAM column address
//   o_scan_row     RAM row address (top half; bottom half is row + ROWS)
//   o_plane        BCM plane, selects the RAM bit
//   o_panel_clk    panel shift clock
//   o_panel_lat    panel latch
//   o_panel_oe_n   panel output enable, active low
//   o_addr_out     panel row-select lines A..E
//   o_frame_done   1-cycle pulse after the last SHOW of a frame
//
// Configuration
//   BCM_BRIGHTNESS_EN  when defined, adds i_brightness. During SHOW the panel is
//                      lit only for the first ((BASE_ON<<plane)*(brightness+1))>>4
//                      cycles; the SHOW length itself is unchanged. brightness
//                      is captured in LATCH.
//
// Every output is a flop; nothing combinational reaches the pins.
// -----------------------------------------------------------------------------
module hub75_bcm_ctrl #(
    parameter int COLS      = 64,
    parameter int ROWS      = 32,
    parameter int BITS      = 5,
    parameter int BASE_ON   = 8,
    parameter int BLANK_CYC = 2,
    localparam int COL_W    = $clog2(COLS),
    localparam int ROW_W    = $clog2(ROWS),
    localparam int PLANE_W  = $clog2(BITS)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_enable,
    input  logic               i_swap_req,
`ifdef BCM_BRIGHTNESS_EN
    input  logic [3:0]         i_brightness,
`endif
    output logic               o_swap_ack,
    output logic               o_buf_sel,
    output logic               o_rd_en,
    output logic [COL_W-1:0]   o_col,
    output logic [ROW_W-1:0]   o_scan_row,
    output logic [PLANE_W-1:0] o_plane,
    output logic               o_panel_clk,
    output logic               o_panel_lat,
    output logic               o_panel_oe_n,
    output logic [ROW_W-1:0]   o_addr_out,
    output logic               o_frame_done
);

    // -------------------------------------------------------------------------
    // Sizing
    // -------------------------------------------------------------------------
    // One phase counter serves every state; it must reach COLS (last SHIFT
    // cycle) and the longest SHOW length minus one.
    localparam int SHOW_MAX = BASE_ON << (BITS - 1);
    localparam int CNT_MAX  = (SHOW_MAX > COLS + 1) ? SHOW_MAX : COLS + 1;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int SL_W     = CNT_W + 1;

    localparam logic [CNT_W-1:0]   C_COLS       = CNT_W'(COLS);
    localparam logic [CNT_W-1:0]   C_BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [COL_W-1:0]   C_COL_LAST   = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]   C_ROW_LAST   = ROW_W'(ROWS - 1);
    localparam logic [PLANE_W-1:0] C_PLANE_LAST = PLANE_W'(BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_BLANK,
        ST_LATCH,
        ST_SHOW
    } state_t;

    // -------------------------------------------------------------------------
    // State and counters
    // -------------------------------------------------------------------------
    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [COL_W-1:0]   r_col;
    logic [ROW_W-1:0]   r_row;
    logic [PLANE_W-1:0] r_plane;

    // Registered pin / RAM-side outputs
    logic               r_rd_en;
    logic               r_panel_clk;
    logic               r_panel_lat;
    logic               r_panel_oe_n;
    logic [ROW_W-1:0]   r_addr_out;
    logic               r_buf_sel;
    logic               r_swap_ack;
    logic               r_frame_done;

    // Next-state values
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [COL_W-1:0]   w_col_nxt;
    logic [ROW_W-1:0]   w_row_nxt;
    logic [PLANE_W-1:0] w_plane_nxt;
    logic               w_frame_end;
    logic               w_show_on;

    // SHOW length of the current plane and its last counter value.
    logic [SL_W-1:0]    w_show_len;
    logic [CNT_W-1:0]   w_show_last;

    assign w_show_len  = SL_W'(BASE_ON) << r_plane;
    assign w_show_last = CNT_W'(w_show_len - SL_W'(1));

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave it unassigned (no latches).
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_plane_nxt = r_plane;
        w_frame_end = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (i_enable) begin
                    w_state_nxt = ST_SHIFT;
                end
            end

            // COLS read cycles plus one trailing cycle so the last pixel's
            // panel_clk (rd_en delayed by one) still falls inside SHIFT.
            ST_SHIFT: begin
                if (r_cnt < C_COLS) begin
                    w_col_nxt = (r_col == C_COL_LAST) ? '0 : r_col + COL_W'(1);
                end
                if (r_cnt == C_COLS) begin
                    w_state_nxt = ST_BLANK;
                    w_cnt_nxt   = '0;
                end
            end

            ST_BLANK: begin
                if (r_cnt == C_BLANK_LAST) begin
                    w_state_nxt = ST_LATCH;
                    w_cnt_nxt   = '0;
                end
            end

            ST_LATCH: begin
                w_state_nxt = ST_SHOW;
                w_cnt_nxt   = '0;
            end

            // Leaving SHOW is the only point where the scan position advances
            // and where a running scan looks at i_enable again.
            ST_SHOW: begin
                if (r_cnt == w_show_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = i_enable ? ST_SHIFT : ST_IDLE;
                    if (r_plane == C_PLANE_LAST) begin
                        w_plane_nxt = '0;
                        if (r_row == C_ROW_LAST) begin
                            w_row_nxt   = '0;
                            w_frame_end = 1'b1;
                        end else begin
                            w_row_nxt = r_row + ROW_W'(1);
                        end
                    end else begin
                        w_plane_nxt = r_plane + PLANE_W'(1);
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output-enable window
    // -------------------------------------------------------------------------
`ifdef BCM_BRIGHTNESS_EN
    // Lit length of the SHOW phase. It is computed from the live brightness
    // input while in LATCH (that value is used for the first SHOW cycle) and
    // held in r_on_len for the rest of the plane.
    logic [CNT_W-1:0]  r_on_len;
    logic [CNT_W-1:0]  w_on_len;
    logic [SL_W+3:0]   w_on_prod;

    always_comb begin
        w_on_prod = (SL_W + 4)'(w_show_len) * (SL_W + 4)'({1'b0, i_brightness} + 5'd1);
        w_on_len  = r_on_len;
        if (r_state == ST_LATCH) begin
            w_on_len = CNT_W'(w_on_prod >> 4);
        end
    end

    assign w_show_on = (w_state_nxt == ST_SHOW) && (w_cnt_nxt < w_on_len);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_on_len <= '0;
        end else begin
            r_on_len <= w_on_len;
        end
    end
`else
    assign w_show_on = (w_state_nxt == ST_SHOW);
`endif

    // -------------------------------------------------------------------------
    // Registers. Outputs are derived from next-state values so each pin lines
    // up with the state it belongs to while still coming straight from a flop.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples pre-edge values regardless of statement order.
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_plane      <= '0;
            r_rd_en      <= 1'b0;
            r_panel_clk  <= 1'b0;
            r_panel_lat  <= 1'b0;
            r_panel_oe_n <= 1'b1;
            r_addr_out   <= '0;
            r_buf_sel    <= 1'b0;
            r_swap_ack   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_col        <= w_col_nxt;
            r_row        <= w_row_nxt;
            r_plane      <= w_plane_nxt;

            r_rd_en      <= (w_state_nxt == ST_SHIFT) && (w_cnt_nxt < C_COLS);
            // Shift clock trails the read strobe by one cycle, matching the
            // RAM's one-cycle read latency.
            r_panel_clk  <= r_rd_en;
            r_panel_lat  <= (w_state_nxt == ST_LATCH);
            r_panel_oe_n <= ~w_show_on;

            // Row lines change together with the latch pulse, well before the
            // panel is lit again in SHOW.
            if (w_state_nxt == ST_LATCH) begin
                r_addr_out <= r_row;
            end

            // Swap only at a frame boundary; a request raised mid-frame simply
            // stays pending until the next one.
            r_frame_done <= w_frame_end;
            r_swap_ack   <= w_frame_end & i_swap_req;
            if (w_frame_end && i_swap_req) begin
                r_buf_sel <= ~r_buf_sel;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output mapping
    // -------------------------------------------------------------------------
    assign o_swap_ack   = r_swap_ack;
    assign o_buf_sel    = r_buf_sel;
    assign o_rd_en      = r_rd_en;
    assign o_col        = r_col;
    assign o_scan_row   = r_row;
    assign o_plane      = r_plane;
    assign o_panel_clk  = r_panel_clk;
    assign o_panel_lat  = r_panel_lat;
    assign o_panel_oe_n = r_panel_oe_n;
    assign o_addr_out   = r_addr_out;
    assign o_frame_done = r_frame_done;

endmodule
